tile_draw_scheduler: RTL and testbench

TILE_DRAW_SCHEDULER -- requirements
Module: tile_draw_scheduler

---
 rtl/tile_draw_scheduler.sv | 82 ++++++++
 tb/tb_tile_draw_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tile_draw_scheduler.sv
// tile_draw_scheduler: round-robin arbiter that range-checks a grid tile, launches one draw and acks it on completion or timeout
module tile_draw_scheduler #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] req_gx,
  input  logic [15:0] req_gy,
  input  logic [7:0]  req_sprite,
  output logic [3:0]  ack,
  output logic        err,
  output logic        draw_start,
  output logic [3:0]  draw_gx,
  output logic [3:0]  draw_gy,
  output logic [1:0]  draw_sprite,
  input  logic        draw_done,
  output logic        busy,
  output logic [1:0]  grant_id
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic [15:0] timer;
  logic err_flag, found, oob, tmo;
  logic [1:0] last_grant, win, idx;
  logic [3:0] win_gx, win_gy;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign win_gx = req_gx[{win, 2'b00} +: 4];
  assign win_gy = req_gy[{win, 2'b00} +: 4];
  assign oob = (win_gx > 4'd7) || (win_gy > 4'd5);
  assign tmo = (({1'b0, timer} + 17'd1) == 17'(TIMEOUT));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? (oob ? ACK : LAUNCH) : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = (draw_done || tmo) ? ACK : WAIT;
      ACK:     state_nx = req[grant_id] ? ACK : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      timer       <= '0;
      err_flag    <= 1'b0;
      last_grant  <= 2'd3;
      grant_id    <= '0;
      draw_gx     <= '0;
      draw_gy     <= '0;
      draw_sprite <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        draw_gx     <= win_gx;
        draw_gy     <= win_gy;
        draw_sprite <= req_sprite[{win, 1'b0} +: 2];
        grant_id    <= win;
        err_flag    <= oob;
      end
      if (state == LAUNCH) timer <= '0;
      if (state == WAIT) timer <= timer + 16'd1;
      if (state == WAIT && state_nx == ACK) err_flag <= !draw_done;
      if (state == ACK && !req[grant_id]) last_grant <= grant_id;
    end
  end
  assign ack        = (state == ACK) ? (4'b0001 << grant_id) : 4'b0000;
  assign err        = (state == ACK) && err_flag;
  assign draw_start = (state == LAUNCH);
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// tb_tile_draw_scheduler: directed and randomized transactions checked against a transaction-level round-robin model
module tb_tile_draw_scheduler;
  logic clk = 1'b0, resetn = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] req_gx = '0, req_gy = '0;
  logic [7:0] req_sprite = '0;
  logic draw_done = 1'b0;
  logic [3:0] ack, draw_gx, draw_gy;
  logic err, draw_start, busy;
  logic [1:0] draw_sprite, grant_id;
  logic [3:0] req_t = '0;
  logic [15:0] gx_t = '0, gy_t = '0;
  logic [7:0] sp_t = '0;
  logic done_t = 1'b0;
  logic [3:0] ack_t, dgx_t, dgy_t;
  logic err_t, start_t, busy_t;
  logic [1:0] dsp_t, gid_t;
  int checks = 0, failures = 0;
  logic [1:0] lg;
  tile_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .req(req), .req_gx(req_gx), .req_gy(req_gy),
    .req_sprite(req_sprite), .ack(ack), .err(err), .draw_start(draw_start),
    .draw_gx(draw_gx), .draw_gy(draw_gy), .draw_sprite(draw_sprite),
    .draw_done(draw_done), .busy(busy), .grant_id(grant_id)
  );
  tile_draw_scheduler #(.TIMEOUT(16)) dut_t (
    .clk(clk), .resetn(resetn), .req(req_t), .req_gx(gx_t), .req_gy(gy_t),
    .req_sprite(sp_t), .ack(ack_t), .err(err_t), .draw_start(start_t),
    .draw_gx(dgx_t), .draw_gy(dgy_t), .draw_sprite(dsp_t),
    .draw_done(done_t), .busy(busy_t), .grant_id(gid_t)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int i = 1; i <= 4; i++)
      if (r[(int'(last) + i) % 4]) return 2'((int'(last) + i) % 4);
    return 2'd0;
  endfunction
  task automatic check_reset;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_start", draw_start, 0);
    chk("rst_gx", draw_gx, 0);
    chk("rst_gy", draw_gy, 0);
    chk("rst_sprite", draw_sprite, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
  endtask
  task automatic txn(input logic [3:0] r, input logic [15:0] gx, input logic [15:0] gy,
                     input logic [7:0] sp, input int d);
    logic [1:0] w, esp;
    logic [3:0] egx, egy, wbit;
    logic bad;
    w = rr_pick(r, lg);
    wbit = 4'b0001 << w;
    egx = gx[w*4 +: 4];
    egy = gy[w*4 +: 4];
    esp = sp[w*2 +: 2];
    bad = (egx > 7) || (egy > 5);
    req = r;
    req_gx = gx;
    req_gy = gy;
    req_sprite = sp;
    step;
    chk("grant", grant_id, w);
    chk("cap_gx", draw_gx, egx);
    chk("cap_gy", draw_gy, egy);
    chk("cap_sprite", draw_sprite, esp);
    chk("busy", busy, 1);
    chk("start", draw_start, !bad);
    if (!bad) begin
      chk("ack_launch", ack, 0);
      step;
      chk("start_pulse", draw_start, 0);
      repeat (d) begin
        req = 4'($urandom) | wbit;
        req_gx = 16'($urandom);
        req_gy = 16'($urandom);
        step;
        chk("ack_wait", ack, 0);
      end
      draw_done = 1'b1;
      step;
      draw_done = 1'b0;
    end
    chk("ack", ack, wbit);
    chk("err", err, bad);
    repeat (2) begin
      req = 4'($urandom) | wbit;
      req_gx = 16'($urandom);
      req_sprite = 8'($urandom);
      step;
      chk("ack_hold", ack, wbit);
      chk("gx_hold", draw_gx, egx);
      chk("sprite_hold", draw_sprite, esp);
    end
    req = '0;
    step;
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
    chk("grant_keep", grant_id, w);
    lg = w;
  endtask
  initial begin
    int n;
    logic [15:0] gx, gy;
    resetn = 1'b0;
    repeat (2) step;
    check_reset;
    chk("rst_busy_t", busy_t, 0);
    resetn = 1'b1;
    lg = 2'd3;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 16'h1234, 16'h1111, 8'h1b, 3);
      chk("rr_order", grant_id, i % 4);
    end
    txn(4'b0001, 16'h0003, 16'h0002, 8'h01, 400);
    txn(4'b0100, 16'h0800, 16'h0000, 8'h00, 0);
    draw_done = 1'b1;
    step;
    draw_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_ack", ack, 0);
    req = 4'b0001;
    req_gx = 16'h0005;
    req_gy = 16'h0003;
    step;
    step;
    step;
    resetn = 1'b0;
    req = '0;
    step;
    resetn = 1'b1;
    check_reset;
    lg = 2'd3;
    draw_done = 1'b1;
    step;
    draw_done = 1'b0;
    chk("post_rst_ack", ack, 0);
    chk("post_rst_busy", busy, 0);
    txn(4'b0010, 16'h0040, 16'h0030, 8'h0c, 5);
    req_t = 4'b0001;
    gx_t = 16'h0001;
    gy_t = 16'h0001;
    sp_t = 8'h02;
    step;
    chk("t_start", start_t, 1);
    chk("t_gx", dgx_t, 1);
    chk("t_gy", dgy_t, 1);
    chk("t_sprite", dsp_t, 2);
    chk("t_grant", gid_t, 0);
    step;
    n = 0;
    while (ack_t == 4'b0000 && n < 100) begin
      step;
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_ack", ack_t, 4'b0001);
    chk("timeout_err", err_t, 1);
    req_t = '0;
    step;
    chk("timeout_idle", busy_t, 0);
    req_t = 4'b0001;
    step;
    step;
    repeat (15) step;
    done_t = 1'b1;
    step;
    done_t = 1'b0;
    chk("tie_ack", ack_t, 4'b0001);
    chk("tie_err", err_t, 0);
    req_t = '0;
    step;
    chk("tie_idle", busy_t, 0);
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        gx[k*4 +: 4] = 4'($urandom_range(0, 9));
        gy[k*4 +: 4] = 4'($urandom_range(0, 7));
      end
      txn(4'($urandom_range(1, 15)), gx, gy, 8'($urandom), int'($urandom_range(0, 30)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
